// File: rtl/nios2_system_onchip_memory_arbiter_if.sv
// Avalon-MM master port bundle shared by both masters of the on-chip RAM arbiter.
// The master modport is the requester's view; the arbiter uses the slave modport.
interface nios2_system_onchip_memory_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic                chipselect;
  logic                write;
  logic [DATA_W/8-1:0] byteenable;
  logic [DATA_W-1:0]   writedata;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;

  modport master (
    output address, chipselect, write, byteenable, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, chipselect, write, byteenable, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/nios2_system_onchip_memory_arbiter.sv
// Round-robin arbiter sharing one on-chip RAM port between two Avalon-MM masters.
// Define ONCHIP_ARB_CLEAR_EN to zero the whole RAM after reset before any master is served.
module nios2_system_onchip_memory_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8192
) (
  input  logic                clk,
  input  logic                reset,
  nios2_system_onchip_memory_arbiter_if.slave m0,
  nios2_system_onchip_memory_arbiter_if.slave m1,
  output logic [ADDR_W-1:0]   ram_address,
  output logic                ram_chipselect,
  output logic                ram_write,
  output logic [DATA_W/8-1:0] ram_byteenable,
  output logic [DATA_W-1:0]   ram_writedata,
  output logic                ram_clken,
  input  logic [DATA_W-1:0]   ram_readdata,
  output logic                clear_busy
);

  localparam int BE_W = DATA_W / 8;

  if (DEPTH > (2 ** ADDR_W)) begin : g_depth_check
    $error("DEPTH does not fit in ADDR_W address bits");
  end

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

`ifdef ONCHIP_ARB_CLEAR_EN
  localparam state_t RESET_STATE = ST_CLEAR;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
`else
  localparam state_t RESET_STATE = ST_RUN;
`endif

  state_t state_q, state_d;
  logic   last_grant_q;
  logic   rd_pend_q;
  logic   rd_owner_q;
  logic   grant_valid;
  logic   grant_sel;

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    grant_valid    = 1'b0;
    grant_sel      = 1'b0;
    ram_address    = '0;
    ram_chipselect = 1'b0;
    ram_write      = 1'b0;
    ram_byteenable = '0;
    ram_writedata  = '0;
`ifdef ONCHIP_ARB_CLEAR_EN
    clr_cnt_d      = clr_cnt_q;
`endif

    if (!reset) begin
      case (state_q)
        ST_CLEAR: begin
`ifdef ONCHIP_ARB_CLEAR_EN
          ram_chipselect = 1'b1;
          ram_write      = 1'b1;
          ram_byteenable = '1;
          ram_address    = clr_cnt_q;
          // Hold the counter at the last word; the state change ends the sweep.
          if (clr_cnt_q == LAST_ADDR) begin
            state_d = ST_RUN;
          end else begin
            clr_cnt_d = clr_cnt_q + 1'b1;
          end
`else
          state_d = ST_RUN;
`endif
        end

        default: begin
          // A tie goes to the master that was not served most recently.
          if (m0.chipselect && m1.chipselect) begin
            grant_valid = 1'b1;
            grant_sel   = ~last_grant_q;
          end else if (m0.chipselect) begin
            grant_valid = 1'b1;
            grant_sel   = 1'b0;
          end else if (m1.chipselect) begin
            grant_valid = 1'b1;
            grant_sel   = 1'b1;
          end

          if (grant_valid) begin
            ram_chipselect = 1'b1;
            ram_address    = grant_sel ? m1.address    : m0.address;
            ram_write      = grant_sel ? m1.write      : m0.write;
            ram_byteenable = grant_sel ? m1.byteenable : m0.byteenable;
            ram_writedata  = grant_sel ? m1.writedata  : m0.writedata;
          end
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RESET_STATE;
      last_grant_q <= 1'b1;
      rd_pend_q    <= 1'b0;
      rd_owner_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_pend_q <= grant_valid && !ram_write;
      if (grant_valid) begin
        last_grant_q <= grant_sel;
        rd_owner_q   <= grant_sel;
      end
    end
  end

`ifdef ONCHIP_ARB_CLEAR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      clr_cnt_q <= '0;
    end else begin
      clr_cnt_q <= clr_cnt_d;
    end
  end

  assign clear_busy = (state_q == ST_CLEAR);
`else
  assign clear_busy = 1'b0;
`endif

  assign m0.waitrequest = !(grant_valid && !grant_sel);
  assign m1.waitrequest = !(grant_valid &&  grant_sel);

  // RAM q is unregistered, so the response is routed straight from the pin;
  // reset squashes a response that was in flight when it arrived.
  assign m0.readdatavalid = rd_pend_q && !rd_owner_q && !reset;
  assign m1.readdatavalid = rd_pend_q &&  rd_owner_q && !reset;
  assign m0.readdata      = m0.readdatavalid ? ram_readdata : '0;
  assign m1.readdata      = m1.readdatavalid ? ram_readdata : '0;

  assign ram_clken = 1'b1;

endmodule
